// File: rtl/deserializador_fifo.sv
// deserializador_fifo: serial-to-parallel converter feeding a DEPTH-word FIFO
// drained through a four-phase data_ready/ack_in handshake.
module deserializador_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic                       clk_100KHz,
  input  logic                       reset,
  input  logic                       data_in,
  input  logic                       write_in,
  input  logic                       ack_in,
  output logic                       status_out,
  output logic [WIDTH-1:0]           data_out,
  output logic                       data_ready,
  output logic [$clog2(DEPTH+1)-1:0] word_count,
  output logic                       drop_out
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int BW = $clog2(WIDTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] PLAST = PW'(DEPTH-1);
  localparam logic [BW-1:0] BLAST = BW'(WIDTH-1);
  typedef enum logic [1:0] {OUT_IDLE, OUT_VALID, OUT_ACK} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] shift_q, shift_d, data_q;
  logic [BW-1:0]    bit_cnt_q;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             status_q, drop_q, ready_q;
  logic             accept, last, push, pop;
  always_comb begin
    accept  = write_in && !status_q;
    last    = bit_cnt_q == BLAST;
    push    = accept && last;
    pop     = state_q == OUT_ACK && !ack_in;
    shift_d = MSB_FIRST != 0 ? {shift_q[WIDTH-2:0], data_in} : {data_in, shift_q[WIDTH-1:1]};
    count_d = count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk_100KHz)
    if (!reset && push) mem_q[wr_ptr_q] <= shift_d;
  always_ff @(posedge clk_100KHz) begin
    if (reset) begin
      state_q   <= OUT_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      status_q  <= 1'b0;
      drop_q    <= 1'b0;
      ready_q   <= 1'b0;
      data_q    <= '0;
    end else begin
      if (accept) begin
        shift_q   <= shift_d;
        bit_cnt_q <= last ? '0 : bit_cnt_q + BW'(1);
      end
      if (push) wr_ptr_q <= wr_ptr_q == PLAST ? '0 : wr_ptr_q + PW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q == PLAST ? '0 : rd_ptr_q + PW'(1);
      count_q  <= count_d;
      status_q <= count_d == FULL;
      drop_q   <= write_in && status_q;
      // head is stable from OUT_VALID until the pop, so it is captured once on entry
      case (state_q)
        OUT_IDLE: if (count_q != '0) begin
          state_q <= OUT_VALID;
          ready_q <= 1'b1;
          data_q  <= mem_q[rd_ptr_q];
        end
        OUT_VALID: if (ack_in) state_q <= OUT_ACK;
        OUT_ACK: if (!ack_in) begin
          state_q <= OUT_IDLE;
          ready_q <= 1'b0;
          data_q  <= '0;
        end
        default: state_q <= OUT_IDLE;
      endcase
    end
  end
  assign status_out = status_q;
  assign data_out   = data_q;
  assign data_ready = ready_q;
  assign word_count = count_q;
  assign drop_out   = drop_q;
endmodule

// File: tb/tb_deserializador_fifo.sv
// tb_deserializador_fifo: MSB-first and LSB-first instances driven in lockstep
// and compared every cycle against a queue-based reference model.
module tb_deserializador_fifo;
  logic clk = 1'b0, rst = 1'b1, din = 1'b0, wr = 1'b0, ack = 1'b0;
  logic st_m, rdy_m, drop_m, st_l, rdy_l, drop_l;
  logic [7:0] do_m, do_l;
  logic [1:0] wc_m, wc_l;
  int checks = 0, fails = 0, drops = 0;
  logic [7:0] q[$];
  logic [7:0] acc = '0;
  int n = 0, ph = 0;
  logic e_drop = 1'b0;
  always #5 clk = ~clk;
  deserializador_fifo u_msb (.clk_100KHz(clk), .reset(rst), .data_in(din), .write_in(wr), .ack_in(ack),
    .status_out(st_m), .data_out(do_m), .data_ready(rdy_m), .word_count(wc_m), .drop_out(drop_m));
  deserializador_fifo #(.MSB_FIRST(0)) u_lsb (.clk_100KHz(clk), .reset(rst), .data_in(din), .write_in(wr), .ack_in(ack),
    .status_out(st_l), .data_out(do_l), .data_ready(rdy_l), .word_count(wc_l), .drop_out(drop_l));
  function automatic logic [7:0] rev(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  // one clock: model advances on pre-edge state, then every output of both instances is compared
  task automatic step(input logic r, input logic d, input logic w, input logic a);
    logic full, pop, psh;
    logic [7:0] head;
    rst = r; din = d; wr = w; ack = a;
    @(posedge clk);
    if (r) begin
      q.delete(); acc = '0; n = 0; ph = 0; e_drop = 1'b0;
    end else begin
      full = q.size() == 2;
      pop = ph == 2 && !a;
      psh = 1'b0;
      e_drop = w && full;
      if (w && !full) begin
        acc = {acc[6:0], d};
        n++;
        if (n == 8) begin psh = 1'b1; n = 0; end
      end
      if (ph == 0 && q.size() > 0) ph = 1;
      else if (ph == 1 && a) ph = 2;
      else if (ph == 2 && !a) ph = 0;
      if (pop) void'(q.pop_front());
      if (psh) q.push_back(acc);
    end
    #1;
    head = ph != 0 ? q[0] : 8'h00;
    chk("ready_msb", rdy_m, ph != 0);
    chk("ready_lsb", rdy_l, ph != 0);
    chk("data_msb", do_m, head);
    chk("data_lsb", do_l, rev(head));
    chk("count", wc_m, q.size());
    chk("count_lsb", wc_l, q.size());
    chk("status", st_m, q.size() == 2);
    chk("status_lsb", st_l, q.size() == 2);
    chk("drop", drop_m, e_drop);
    chk("drop_lsb", drop_l, e_drop);
    if (drop_m) drops++;
  endtask
  task automatic send(input logic [7:0] w, input int nb, input logic a);
    for (int i = 7; i > 7 - nb; i--) step(1'b0, w[i], 1'b1, a);
  endtask
  task automatic idle(input int k, input logic a);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 1'b0, a);
  endtask
  initial begin
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("reset_data", do_m, 0);
    chk("reset_ready", rdy_m, 0);
    idle(2, 1'b0);
    chk("reset_no_word", wc_m, 0);
    send(8'h80, 8, 1'b0);
    chk("first_count", wc_m, 1);
    chk("first_not_ready", rdy_m, 0);
    idle(1, 1'b0);
    chk("order_msb", do_m, 8'h80);
    chk("order_lsb", do_l, 8'h01);
    idle(3, 1'b1);
    idle(2, 1'b0);
    send(8'hA5, 8, 1'b0);
    idle(1, 1'b0);
    chk("hs_present", do_m, 8'hA5);
    idle(3, 1'b1);
    chk("hs_hold_ready", rdy_m, 1);
    idle(1, 1'b0);
    chk("hs_released", rdy_m, 0);
    chk("hs_data_zero", do_m, 0);
    chk("hs_count", wc_m, 0);
    idle(2, 1'b0);
    send(8'h11, 8, 1'b0);
    send(8'h22, 8, 1'b0);
    chk("full_status", st_m, 1);
    chk("full_count", wc_m, 2);
    drops = 0;
    send(8'hA0, 4, 1'b0);
    chk("drop_pulses", drops, 4);
    idle(1, 1'b0);
    chk("full_head", do_m, 8'h11);
    idle(2, 1'b1);
    idle(1, 1'b0);
    chk("pop_status", st_m, 0);
    idle(1, 1'b0);
    chk("second_head", do_m, 8'h22);
    idle(2, 1'b1);
    idle(2, 1'b0);
    send(8'h11, 8, 1'b0);
    idle(1, 1'b0);
    idle(1, 1'b1);
    send(8'h22, 7, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("simul_count", wc_m, 1);
    idle(1, 1'b0);
    chk("simul_next", do_m, 8'h22);
    idle(1, 1'b1);
    idle(2, 1'b0);
    send(8'hFF, 5, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    send(8'h3C, 8, 1'b0);
    idle(1, 1'b0);
    chk("mid_word_reset", do_m, 8'h3C);
    idle(1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("ack_reset_count", wc_m, 0);
    send(8'hC3, 8, 1'b0);
    idle(1, 1'b0);
    chk("ack_reset_word", do_m, 8'hC3);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) ack = ~ack;
      step(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7, ack);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
